// File: rtl/comb_decimator.sv
// CIC comb section: keeps every DECIM-th accepted sample and outputs its
// difference against the kept sample DELAY decimated samples earlier.
module comb_decimator #(
    parameter int DATA_WIDTH = 8,
    parameter int DECIM      = 4,
    parameter int DELAY      = 1,
    localparam int PW        = (DECIM > 1) ? $clog2(DECIM) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  resync,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [PW-1:0]         phase
);

    // Modular difference; the extra sign bit keeps the subtraction explicit
    // and the truncation recovers the increment of a same-width wrapping sum.
    function automatic logic [DATA_WIDTH-1:0] wrap_diff(
        input logic [DATA_WIDTH-1:0] a,
        input logic [DATA_WIDTH-1:0] b
    );
        logic signed [DATA_WIDTH:0] d;
        d = signed'({1'b0, a}) - signed'({1'b0, b});
        return d[DATA_WIDTH-1:0];
    endfunction

    logic [DATA_WIDTH-1:0] dline [DELAY];
    logic                  accept;
    logic                  last_phase;
    logic                  decimate;
    logic                  consume;

    assign in_ready   = !out_valid || out_ready;
    assign accept     = in_valid && in_ready;
    assign last_phase = (phase == PW'(DECIM - 1));
    assign decimate   = accept && last_phase;
    assign consume    = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            phase     <= '0;
            for (int i = 0; i < DELAY; i++) begin
                dline[i] <= '0;
            end
        end else begin
            // resync wins over the increment, but the coinciding sample was
            // already classified at its pre-resync phase through decimate.
            if (resync) begin
                phase <= '0;
            end else if (accept) begin
                phase <= last_phase ? '0 : phase + PW'(1);
            end

            if (decimate) begin
                out_data  <= wrap_diff(in_data, dline[DELAY-1]);
                out_valid <= 1'b1;
                dline[0]  <= in_data;
                for (int i = 1; i < DELAY; i++) begin
                    dline[i] <= dline[i-1];
                end
            end else if (consume) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_comb_decimator.sv
// Directed bench for comb_decimator across three parameter sets sharing one clock/reset.
module tb_comb_decimator;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // DECIM=4, DELAY=1
    logic       iv4 = 0, ir4, rs4 = 0, ov4, or4 = 1;
    logic [7:0] id4 = 0, od4;
    logic [1:0] ph4;
    // DECIM=1, DELAY=1
    logic       iv1 = 0, ir1, rs1 = 0, ov1, or1 = 1;
    logic [7:0] id1 = 0, od1;
    logic [0:0] ph1;
    // DECIM=1, DELAY=2
    logic       iv2 = 0, ir2, rs2 = 0, ov2, or2 = 1;
    logic [7:0] id2 = 0, od2;
    logic [0:0] ph2;

    int tests = 0;
    int fails = 0;

    comb_decimator #(.DATA_WIDTH(8), .DECIM(4), .DELAY(1)) u4 (
        .clk(clk), .rst(rst), .in_valid(iv4), .in_ready(ir4), .in_data(id4),
        .resync(rs4), .out_valid(ov4), .out_ready(or4), .out_data(od4), .phase(ph4)
    );
    comb_decimator #(.DATA_WIDTH(8), .DECIM(1), .DELAY(1)) u1 (
        .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1), .in_data(id1),
        .resync(rs1), .out_valid(ov1), .out_ready(or1), .out_data(od1), .phase(ph1)
    );
    comb_decimator #(.DATA_WIDTH(8), .DECIM(1), .DELAY(2)) u2 (
        .clk(clk), .rst(rst), .in_valid(iv2), .in_ready(ir2), .in_data(id2),
        .resync(rs2), .out_valid(ov2), .out_ready(or2), .out_data(od2), .phase(ph2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int exp_ramp [3] = '{9, 12, 12};
        int rs_vals  [4] = '{110, 111, 112, 150};
        int d2_in    [4] = '{10, 20, 35, 55};
        int d2_out   [4] = '{10, 20, 25, 35};

        // Reset state
        tick();
        tick();
        chk("rst_out_valid", ov4, 0);
        chk("rst_out_data", od4, 0);
        chk("rst_phase", ph4, 0);
        chk("rst_in_ready", ir4, 1);
        rst = 1'b0;

        // Accumulator ramp 0,3,...,33 through DECIM=4
        for (int i = 0; i < 12; i++) begin
            iv4 = 1'b1;
            id4 = 8'(3 * i);
            chk("ramp_phase", ph4, i % 4);
            tick();
            chk("ramp_valid", ov4, (i % 4) == 3);
            if ((i % 4) == 3) chk("ramp_data", od4, exp_ramp[i / 4]);
        end

        // resync coinciding with an accept; history (33) must survive
        id4 = 8'd100; tick();
        id4 = 8'd101; tick();
        chk("rs_phase_pre", ph4, 2);
        id4 = 8'd102; rs4 = 1'b1; tick();
        rs4 = 1'b0;
        chk("rs_phase_post", ph4, 0);
        chk("rs_no_output", ov4, 0);
        for (int j = 0; j < 4; j++) begin
            chk("rs_phase_seq", ph4, j);
            id4 = 8'(rs_vals[j]);
            tick();
            chk("rs_valid", ov4, j == 3);
        end
        chk("rs_data", od4, 117);

        // Hold a pending result, then reset mid-stream
        iv4 = 1'b0;
        or4 = 1'b0;
        tick();
        chk("hold4_valid", ov4, 1);
        chk("hold4_ready", ir4, 0);
        chk("hold4_data", od4, 117);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_valid", ov4, 0);
        chk("midrst_ready", ir4, 1);
        chk("midrst_phase", ph4, 0);
        chk("midrst_data", od4, 0);
        or4 = 1'b1;
        iv4 = 1'b1;
        id4 = 8'd1; tick();
        id4 = 8'd2; tick();
        id4 = 8'd3; tick();
        chk("midrst_phase3", ph4, 3);
        id4 = 8'd77; tick();
        iv4 = 1'b0;
        chk("midrst_first_valid", ov4, 1);
        chk("midrst_first_data", od4, 77);

        // Wrap-around with DECIM=1 (u1 was just reset)
        iv1 = 1'b1; id1 = 8'd250; tick();
        chk("wrap_valid0", ov1, 1);
        chk("wrap_data0", od1, 250);
        id1 = 8'd6; tick();
        chk("wrap_data1", od1, 12);
        chk("wrap_phase", ph1, 0);
        iv1 = 1'b0; tick();
        chk("wrap_drain", ov1, 0);

        // Backpressure: needs fresh history
        rst = 1'b1; tick(); rst = 1'b0;
        or1 = 1'b0;
        iv1 = 1'b1; id1 = 8'd5; tick();
        chk("bp_valid", ov1, 1);
        chk("bp_data", od1, 5);
        id1 = 8'd9;
        for (int k = 0; k < 10; k++) begin
            chk("bp_in_ready", ir1, 0);
            tick();
            chk("bp_hold_data", od1, 5);
            chk("bp_hold_valid", ov1, 1);
        end
        or1 = 1'b1;
        #1;
        chk("bp_ready_comb", ir1, 1);
        tick();
        chk("bp_nobubble_valid", ov1, 1);
        chk("bp_nobubble_data", od1, 4);
        iv1 = 1'b0; tick();
        chk("bp_drain", ov1, 0);

        // DELAY=2, DECIM=1
        iv2 = 1'b1;
        for (int m = 0; m < 4; m++) begin
            id2 = 8'(d2_in[m]);
            tick();
            chk("d2_valid", ov2, 1);
            chk("d2_data", od2, d2_out[m]);
        end
        iv2 = 1'b0;
        tick();
        chk("d2_drain", ov2, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/comb_decimator.md
Name: comb_decimator

Overview:
- Streaming differencer-decimator: the inverse of the running-sum accumulator stage.
- Keeps every DECIM-th accepted input sample, then outputs the difference between that sample and the kept sample DELAY decimated samples earlier.
- Placed downstream of an accumulator chain, it recovers per-interval increments (CIC comb section).
- Valid/ready handshake on both sides, registered output.

Parameters:
- DATA_WIDTH, 8, bit width of input samples, delay-line entries and output difference.
- DECIM, 4, decimation ratio R (>=1); one output per DECIM accepted inputs.
- DELAY, 1, differential delay M (>=1); depth of the decimated-sample delay line.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous reset, active-high.
- in_valid  input  1  input sample present.
- in_ready  output  1  block can accept a sample this cycle.
- in_data  input  DATA_WIDTH  input sample, unsigned or two's complement, treated modulo 2^DATA_WIDTH.
- resync  input  1  restart the decimation phase counter without clearing history.
- out_valid  output  1  out_data holds an unconsumed result.
- out_ready  input  1  downstream accepts the result.
- out_data  output  DATA_WIDTH  difference x[k] - x[k-DELAY] over decimated samples, modulo 2^DATA_WIDTH.
- phase  output  clog2(DECIM) (min 1)  current decimation phase count.

Behaviour:
- Interface: one clock (clk), synchronous active-high reset (rst). rst is sampled on the rising clk edge and takes priority over every other input.
- Reset values:
  - out_valid=0, out_data=0, phase=0.
  - All DELAY delay-line entries = 0.
  - in_ready=1 in the cycle after reset deasserts.
- Accept:
  - Input is accepted when in_valid && in_ready at a rising edge.
  - in_ready = !out_valid || out_ready. This is combinational from out_valid and out_ready, and does not depend on in_valid.
- Phase counter:
  - Increments on each accepted sample and wraps DECIM-1 -> 0.
  - The sample accepted with phase==DECIM-1 is the decimated sample.
  - DECIM=1 means every sample is decimated; phase is constant 0.
- Decimated sample x (accepted at edge t):
  - out_data <= x - dline[DELAY-1], truncated to DATA_WIDTH (wrap-around). This is exactly correct when the upstream accumulator wraps at the same width.
  - Delay line shifts: dline[0] <= x, dline[i] <= dline[i-1].
  - out_valid <= 1.
  - Latency: one cycle from accept edge to out_valid/out_data visible.
- Non-decimated accepted samples: only phase changes; delay line and output are untouched.
- Output handshake:
  - The result is consumed at an edge with out_valid && out_ready. out_valid <= 0 unless a new decimated sample is accepted at the same edge.
  - Simultaneous consume and new decimated accept: out_valid stays 1 and out_data takes the new value, with no bubble.
  - While out_valid && !out_ready: in_ready=0, and out_data, phase and the delay line are held stable.
- resync:
  - When asserted, phase <= 0 at that edge, regardless of accepts.
  - If an accept coincides, that sample is treated at its pre-resync phase: it is decimated only if phase was DECIM-1, and phase still ends at 0.
  - Delay line and output are unaffected.
- Startup: the first DELAY outputs after reset subtract the zero-filled delay line, e.g. first out_data = first decimated sample.
- Reset mid-operation: a pending output is discarded (out_valid=0), history is cleared, and phase returns to 0. The next accepted sample counts as phase 0.
- in_data is ignored when in_valid=0. Outputs are held when out_ready is low.

Test Plan:
- DECIM=4, DELAY=1, out_ready=1; feed accumulator ramp 0,3,6,...,33 every cycle -> out_data 9, 12, 12 one cycle after accepting 9, 21, 33; phase cycles 0,1,2,3.
- Wrap, DECIM=1, DELAY=1, 8-bit; inputs 250, 6 -> outputs 250, 12 (6-250 mod 256).
- Backpressure, DECIM=1; out_ready=0 after first result 5 -> in_ready=0, out_data holds 5 for 10 cycles; raise out_ready with next sample 9 pending -> consume and new accept on the same edge, out_data=4 with no bubble.
- DELAY=2, DECIM=1; inputs 10, 20, 35, 55 -> outputs 10, 20, 25, 35.
- resync, DECIM=4; after 2 accepts assert resync with an accept -> phase=0; the decimated sample is the 4th subsequent accept; delay line unchanged.
- Reset mid-stream with out_valid=1 and out_ready=0 -> next cycle out_valid=0, in_ready=1, phase=0; the next decimated sample v yields out_data=v.
